// File: rtl/instruction_fetch_decode_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_decode_pkg
//   Shared definitions for the fetch/decode stage and its neighbours:
//   opcode encodings, register codes and instruction field bit positions.
//   Instruction layout (28 bits): [27:24] opcode, [23:16] dest,
//   [15:8] src0, [7:0] src1, [15:0] literal, [23:0] operand.
// ---------------------------------------------------------------------------
package instruction_fetch_decode_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_STO     = 4'd1,
    OP_ADD     = 4'd2,
    OP_SMUL    = 4'd3,
    OP_IMUL1_4 = 4'd4,
    OP_BLE     = 4'd5,
    OP_JMP     = 4'd6,
    OP_LED     = 4'd7
  } opcode_e;

  localparam logic [7:0] REG_R0 = 8'd0;
  localparam logic [7:0] REG_R1 = 8'd1;
  localparam logic [7:0] REG_R2 = 8'd2;
  localparam logic [7:0] REG_R3 = 8'd3;
  localparam logic [7:0] REG_R4 = 8'd4;
  localparam logic [7:0] REG_R5 = 8'd5;
  localparam logic [7:0] REG_R6 = 8'd6;
  localparam logic [7:0] REG_R7 = 8'd7;

  localparam int OPC_MSB     = 27;
  localparam int OPC_LSB     = 24;
  localparam int DEST_MSB    = 23;
  localparam int DEST_LSB    = 16;
  localparam int SRC0_MSB    = 15;
  localparam int SRC0_LSB    = 8;
  localparam int SRC1_MSB    = 7;
  localparam int SRC1_LSB    = 0;
  localparam int LIT_MSB     = 15;
  localparam int LIT_LSB     = 0;
  localparam int OPERAND_MSB = 23;

  // NOP delay count occupies the whole operand field.
  localparam int DELAY_WIDTH = OPERAND_MSB + 1;

endpackage

// File: rtl/instruction_fetch_decode.sv
// ---------------------------------------------------------------------------
// instruction_fetch_decode
//   Program-ROM reader: owns the PC, registers the returned instruction and
//   splits it into fields for execute. JMP and NOP-delay are resolved here;
//   branch redirects and stalls come from execute.
//
// Ports
//   Clock, Reset         clock, synchronous active-high reset
//   oAddress             ROM address (the PC flop)
//   iInstruction         ROM data for oAddress
//   iStall               freeze all state
//   iBranchTaken/Target  redirect from execute (beats everything but Reset)
//   oValid               decoded fields hold a real instruction
//   oOpcode/oDest/oSrc0/oSrc1/oLiteral  instruction fields
//   oPC                  address of the instruction on the outputs
// ---------------------------------------------------------------------------
module instruction_fetch_decode
  import instruction_fetch_decode_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    INSTR_WIDTH  = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  input  logic [INSTR_WIDTH-1:0] iInstruction,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
  output logic                   oValid,
  output logic [3:0]             oOpcode,
  output logic [7:0]             oDest,
  output logic [7:0]             oSrc0,
  output logic [7:0]             oSrc1,
  output logic [15:0]            oLiteral,
  output logic [ADDR_WIDTH-1:0]  oPC
);

  typedef enum logic {S_RUN, S_DELAY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   opc_q, opc_d;
  logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
  logic                    valid_q, valid_d;
  logic [DELAY_WIDTH-1:0]  cnt_q, cnt_d;

  logic [3:0]              fetch_op;
  logic [DELAY_WIDTH-1:0]  fetch_operand;
  logic [ADDR_WIDTH-1:0]   pc_inc;

  assign fetch_op      = iInstruction[OPC_MSB:OPC_LSB];
  assign fetch_operand = iInstruction[OPERAND_MSB:0];
  assign pc_inc        = pc_q + ADDR_WIDTH'(1);  // wraps silently

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    if (iBranchTaken) begin
      // Wrong-path fetch this cycle is dropped; any pending delay is aborted.
      pc_d    = iBranchTarget;
      ir_d    = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = S_RUN;
    end else if (!iStall) begin
      unique case (state_q)
        S_DELAY: begin
          valid_d = 1'b0;
          cnt_d   = cnt_q - DELAY_WIDTH'(1);
          if (cnt_q == DELAY_WIDTH'(1)) state_d = S_RUN;
        end
        S_RUN: begin
          opc_d = pc_q;
          ir_d  = iInstruction;
          if (fetch_op == OP_JMP) begin
            // JMP is consumed here and never reaches execute.
            pc_d    = ADDR_WIDTH'(iInstruction[DEST_MSB:DEST_LSB]);
            ir_d    = '0;
            valid_d = 1'b0;
          end else if (fetch_op == OP_NOP) begin
            valid_d = 1'b0;
            pc_d    = pc_inc;
            cnt_d   = fetch_operand;
            if (fetch_operand != '0) state_d = S_DELAY;
          end else begin
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_VECTOR;
      opc_q   <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oAddress = pc_q;
  assign oValid   = valid_q;
  assign oPC      = opc_q;
  assign oOpcode  = ir_q[OPC_MSB:OPC_LSB];
  assign oDest    = ir_q[DEST_MSB:DEST_LSB];
  assign oSrc0    = ir_q[SRC0_MSB:SRC0_LSB];
  assign oSrc1    = ir_q[SRC1_MSB:SRC1_LSB];
  assign oLiteral = ir_q[LIT_MSB:LIT_LSB];

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_decode
//   Self-checking bench: a behavioural ROM drives the DUT; a reference model
//   tracks PC, outstanding delay cycles and the presented instruction.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_decode;
  import instruction_fetch_decode_pkg::*;

  localparam logic [27:0] DEFAULT_WORD = {OP_LED, 24'h00_1234};

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic [15:0] iBranchTarget = '0;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDest, oSrc0, oSrc1;
  logic [15:0] oLiteral, oPC;

  instruction_fetch_decode dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress),
    .iInstruction(iInstruction), .iStall(iStall),
    .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oValid(oValid), .oOpcode(oOpcode), .oDest(oDest), .oSrc0(oSrc0),
    .oSrc1(oSrc1), .oLiteral(oLiteral), .oPC(oPC)
  );

  always #5 Clock = ~Clock;

  // Program ROM: 64 programmable words, everything above reads DEFAULT_WORD.
  logic [27:0] mem [64];

  function automatic logic [27:0] rom_word(input logic [15:0] a);
    if (a < 16'd64) return mem[a[5:0]];
    return DEFAULT_WORD;
  endfunction

  always_comb iInstruction = rom_word(oAddress);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural view of the fetch stage.
  logic [15:0] m_pc;
  logic [15:0] m_opc;
  logic [27:0] m_ir;
  logic        m_valid;
  int          m_delay;  // remaining delay cycles before fetch resumes

  task automatic model_step(input logic rst, input logic stall, input logic br,
                            input logic [15:0] tgt);
    logic [27:0] w;
    if (rst) begin
      m_pc = 16'd0; m_opc = 16'd0; m_ir = '0; m_valid = 1'b0; m_delay = 0;
    end else if (br) begin
      m_pc = tgt; m_valid = 1'b0; m_delay = 0;
    end else if (stall) begin
      // everything holds
    end else if (m_delay > 0) begin
      m_delay--;
      m_valid = 1'b0;
    end else begin
      w = rom_word(m_pc);
      if (w[27:24] == OP_JMP) begin
        m_valid = 1'b0;
        m_pc    = {8'd0, w[23:16]};
      end else if (w[27:24] == OP_NOP) begin
        m_valid = 1'b0;
        m_delay = int'(w[23:0]);
        m_pc    = m_pc + 16'd1;
      end else begin
        m_valid = 1'b1;
        m_ir    = w;
        m_opc   = m_pc;
        m_pc    = m_pc + 16'd1;
      end
    end
  endtask

  task automatic compare();
    check("addr", 32'(oAddress), 32'(m_pc));
    check("valid", 32'(oValid), 32'(m_valid));
    if (m_valid) begin
      check("pc", 32'(oPC), 32'(m_opc));
      check("opcode", 32'(oOpcode), 32'(m_ir[27:24]));
      check("dest", 32'(oDest), 32'(m_ir[23:16]));
      check("src0", 32'(oSrc0), 32'(m_ir[15:8]));
      check("src1", 32'(oSrc1), 32'(m_ir[7:0]));
      check("literal", 32'(oLiteral), 32'(m_ir[15:0]));
    end
    if (oValid) check("jmp_hidden", 32'(oOpcode == OP_JMP), 32'(0));
  endtask

  // One clock: drive controls, let the edge happen, update model, compare.
  task automatic step(input logic rst, input logic stall, input logic br,
                      input logic [15:0] tgt);
    Reset = rst; iStall = stall; iBranchTaken = br; iBranchTarget = tgt;
    @(posedge Clock);
    model_step(rst, stall, br, tgt);
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = DEFAULT_WORD;
  endtask

  task automatic load_prog_a();
    clear_mem();
    mem[0] = {OP_NOP, 24'd0};
    mem[1] = {OP_STO, REG_R2, 16'd5};
    mem[2] = {OP_STO, REG_R3, 16'd2};
    mem[3] = {OP_IMUL1_4, 24'd0};
    mem[4] = {OP_LED, REG_R1, 16'd0};
    mem[5] = {OP_JMP, 8'd1, 16'd0};
    mem[7] = {OP_ADD, REG_R1, REG_R2, REG_R3};
  endtask

  initial begin
    logic [15:0] seen [$];
    int          first_valid;
    bit          found;
    logic [3:0]  op;

    clear_mem();

    // Reset state: all outputs zero.
    do_reset();
    do_reset();
    check("rst_addr", 32'(oAddress), 32'(0));
    check("rst_valid", 32'(oValid), 32'(0));
    check("rst_fields", {oOpcode, oDest, oSrc0, oSrc1}, 32'(0));
    check("rst_lit_pc", {oLiteral, oPC}, 32'(0));

    // Program A loop: oPC 1,2,3,4 then JMP bubble, repeated.
    load_prog_a();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'd0);
      if (oValid) seen.push_back(oPC);
    end
    check("loop_len", 32'(seen.size() >= 8), 32'(1));
    for (int i = 0; i < 8 && i < seen.size(); i++)
      check("loop_pc", 32'(seen[i]), 32'((i % 4) + 1));

    // NOP 4000 at address 0: address 1 presented on cycle 4002.
    clear_mem();
    mem[0] = {OP_NOP, 24'd4000};
    mem[1] = {OP_STO, REG_R2, 16'd5};
    do_reset();
    first_valid = 0;
    for (int i = 1; i <= 4100 && first_valid == 0; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'd0);
      if (oValid) first_valid = i;
    end
    check("nop4000_cycle", 32'(first_valid), 32'(4002));
    check("nop4000_pc", 32'(oPC), 32'(1));

    // Stall 3 cycles while STO R2,5 is on the outputs.
    load_prog_a();
    do_reset();
    run(2);
    check("stall_pre_pc", 32'(oPC), 32'(1));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'd0);
    check("stall_hold_pc", 32'(oPC), 32'(1));
    check("stall_hold_addr", 32'(oAddress), 32'(2));
    check("stall_hold_lit", 32'(oLiteral), 32'(5));
    run(1);
    check("stall_release_pc", 32'(oPC), 32'(2));

    // Branch on the same cycle JMP 1 is fetched.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'd0);
      if (oAddress == 16'd5) found = 1'b1;
    end
    check("reach_jmp", 32'(found), 32'(1));
    step(1'b0, 1'b0, 1'b1, 16'd7);
    check("br_jmp_addr", 32'(oAddress), 32'(7));
    check("br_jmp_bubble", 32'(oValid), 32'(0));
    run(1);
    check("br_jmp_pc", 32'(oPC), 32'(7));
    check("br_jmp_op", 32'(oOpcode), 32'(OP_ADD));

    // Branch during DELAY with counter at 100.
    mem[0] = {OP_NOP, 24'd100};
    do_reset();
    run(1);
    step(1'b0, 1'b0, 1'b1, 16'd7);
    check("br_dly_addr", 32'(oAddress), 32'(7));
    check("br_dly_bubble", 32'(oValid), 32'(0));
    run(1);
    check("br_dly_pc", 32'(oPC), 32'(7));
    check("br_dly_valid", 32'(oValid), 32'(1));

    // Reset during DELAY (counter 50); then prove state is RUN.
    mem[0] = {OP_NOP, 24'd50};
    do_reset();
    run(1);
    do_reset();
    check("rst_dly_addr", 32'(oAddress), 32'(0));
    check("rst_dly_valid", 32'(oValid), 32'(0));
    mem[0] = {OP_STO, REG_R4, 16'hBEEF};
    run(1);
    check("rst_dly_run", 32'(oValid), 32'(1));
    check("rst_dly_lit", 32'(oLiteral), 32'hBEEF);

    // Reset while stalled.
    load_prog_a();
    do_reset();
    run(2);
    step(1'b0, 1'b1, 1'b0, 16'd0);
    step(1'b1, 1'b1, 1'b0, 16'd0);
    check("rst_stall_addr", 32'(oAddress), 32'(0));
    check("rst_stall_valid", 32'(oValid), 32'(0));
    check("rst_stall_fields", {oOpcode, oDest, oSrc0, oSrc1}, 32'(0));

    // PC wrap: branch to FFFF, ROM default is LED.
    step(1'b0, 1'b0, 1'b1, 16'hFFFF);
    check("wrap_addr_pre", 32'(oAddress), 32'hFFFF);
    run(1);
    check("wrap_addr", 32'(oAddress), 32'(0));
    check("wrap_pc", 32'(oPC), 32'hFFFF);
    check("wrap_op", 32'(oOpcode), 32'(OP_LED));

    // Randomized program and control traffic.
    for (int i = 0; i < 64; i++) begin
      op = 4'($urandom_range(0, 9));
      if (op == OP_NOP)      mem[i] = {op, 24'($urandom_range(0, 5))};
      else if (op == OP_JMP) mem[i] = {op, 8'($urandom_range(0, 63)), 16'($urandom)};
      else                   mem[i] = {op, 24'($urandom)};
    end
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      automatic logic        r  = ($urandom_range(0, 199) == 0);
      automatic logic        s  = ($urandom_range(0, 4) == 0);
      automatic logic        b  = ($urandom_range(0, 19) == 0);
      automatic logic [15:0] t  = ($urandom_range(0, 31) == 0) ? 16'hFFFF
                                                               : 16'($urandom_range(0, 63));
      step(r, s, b, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_decode.md
Name: instruction_fetch_decode

Overview:
- Reader side of the program ROM: owns the program counter, drives the ROM address and registers the returned 28-bit instruction.
- Splits the instruction into opcode/destination/source/literal fields for the execute stage.
- Resolves JMP and NOP-delay locally; accepts branch redirects and stalls from execute.
- Sits between the program ROM and the ALU/register-file stage.

Parameters:
- ADDR_WIDTH, 16, program counter and ROM address width.
- INSTR_WIDTH, 28, instruction width: 4-bit opcode plus 24-bit operand field.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- oAddress  output  ADDR_WIDTH  ROM address; equals the PC register.
- iInstruction  input  INSTR_WIDTH  ROM data, combinational from oAddress.
- iStall  input  1  execute cannot accept; freeze all state.
- iBranchTaken  input  1  execute resolved a taken BLE this cycle.
- iBranchTarget  input  ADDR_WIDTH  redirect address, valid with iBranchTaken.
- oValid  output  1  decoded fields hold a real instruction.
- oOpcode  output  4  instruction[27:24].
- oDest  output  8  instruction[23:16].
- oSrc0  output  8  instruction[15:8].
- oSrc1  output  8  instruction[7:0].
- oLiteral  output  16  instruction[15:0].
- oPC  output  ADDR_WIDTH  address of the instruction currently on the outputs.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - PC = RESET_VECTOR; IR = all zeros; oValid = 0; oPC = 0; delay counter = 0; state = RUN.
  - All decoded outputs read 0.
  - Reset asserted mid-delay or mid-stall aborts that activity. The first fetch is from RESET_VECTOR in the cycle after Reset deasserts.
- Decoded outputs come from a registered IR, so latency is 1 cycle: the instruction at oAddress=A appears with oPC=A on the following edge.
- State RUN, no stall, no branch, each edge:
  - IR <= iInstruction, oPC <= PC, PC <= PC+1.
  - PC wraps from 16'hFFFF to 0 with no flag.
- JMP fetched in RUN:
  - PC <= instruction[23:16], zero-extended.
  - IR is loaded as a bubble: oValid=0, and JMP is never presented to execute.
  - Cost is 1 bubble cycle.
- NOP fetched in RUN:
  - Presented once with oValid=0.
  - Delay counter <= instruction[23:0]. If the count is non-zero, state -> DELAY and PC <= PC+1.
  - NOP with count 0 behaves as a single bubble.
- State DELAY:
  - PC holds; oValid=0; counter decrements by 1 per unstalled cycle.
  - Transition to RUN on the edge where the counter reaches 0. A count of N gives exactly N DELAY cycles, then fetch resumes at the NOP address+1.
- All other opcodes (STO, ADD, SMUL, IMUL*, LED, BLE, ...) are presented with oValid=1.
  - Field meaning is the execute stage's concern; this block does not interpret it.
- Unknown opcode values pass through with oValid=1.
- iStall=1 (and no branch): PC, IR, counter, state and all outputs hold.
- iBranchTaken=1:
  - Highest priority after Reset; overrides stall, JMP and DELAY.
  - PC <= iBranchTarget; IR <= bubble (oValid=0); counter <= 0; state <= RUN.
  - The wrong-path instruction fetched that cycle is discarded.
- Simultaneous JMP fetch and iBranchTaken: the branch wins, and the JMP target is ignored.
- oAddress never glitches between edges; it is driven directly from the PC flop.

Decomposition:
- Opcode encodings (NOP, STO, ADD, SMUL, IMUL1_4, BLE, JMP, LED) and register codes come from the team's shared definitions header; they are not redefined locally.
- Field bit positions (27:24, 23:16, 15:8, 7:0, 15:0) go into that header as named constants.
- State encoding RUN/DELAY is local.
- No sub-module is required. Optionally a 24-bit loadable down-counter, delay_counter, with load/enable/zero signals.

Test Plan:
- Reset then run the 6-word program STO R2,5; STO R3,2; IMUL1_4; LED; JMP 1 -> the oPC sequence after the first NOP's bubble is 1,2,3,4, then a bubble, then 1,2,3,4 repeating. JMP never appears with oValid=1.
- NOP with count 4000 at address 0 -> oValid=0 and oAddress=1 held for 4000 cycles after the NOP edge; address 1 is presented on cycle 4002.
- iStall held 3 cycles while IR=STO R2,5 -> outputs and oAddress are frozen; the next instruction follows one cycle after the stall drops.
- iBranchTaken with target 7 on the same cycle a JMP 1 is fetched, and separately during DELAY with counter=100 -> next oAddress=7, one bubble, delay aborted, oPC=7 next.
- Reset asserted during DELAY (counter=50) and during a stall -> the next edge shows oValid=0, oAddress=0, state RUN.
- Force PC to 16'hFFFF via iBranchTarget with the ROM default returning LED -> the next oAddress is 0 and no flag is raised.
